// File: rtl/pkt_hdr_arb.sv
// Two-requester AXI-stream packet arbiter feeding a header classifier.
// Round-robin grant between packets, packets are never interleaved, and the
// first beat of each packet is tagged with its L3 type taken from the
// EtherType field at tdata[415:400].
// Optional build macro: PKT_HDR_ARB_STATS_EN adds per-port packet counters.
module pkt_hdr_arb #(
   parameter int unsigned TDATA_W = 512,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                 axis_aclk,
   input  logic                 axis_rst,

   input  logic                 s0_axis_tvalid,
   output logic                 s0_axis_tready,
   input  logic                 s0_axis_tlast,
   input  logic [TDATA_W-1:0]   s0_axis_tdata,
   input  logic [TDATA_W/8-1:0] s0_axis_tkeep,

   input  logic                 s1_axis_tvalid,
   output logic                 s1_axis_tready,
   input  logic                 s1_axis_tlast,
   input  logic [TDATA_W-1:0]   s1_axis_tdata,
   input  logic [TDATA_W/8-1:0] s1_axis_tkeep,

   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic [TDATA_W-1:0]   m_axis_tdata,
   output logic [TDATA_W/8-1:0] m_axis_tkeep,
   output logic                 m_axis_tuser_src,
   output logic                 m_axis_tuser_sop,
   output logic [1:0]           m_axis_tuser_l3,

   input  logic                 stats_clr,
   output logic [CNT_W-1:0]     pkt_cnt0,
   output logic [CNT_W-1:0]     pkt_cnt1
);

   localparam int unsigned ETYPE_LSB = 400;
   localparam int unsigned ETYPE_W   = 16;

   localparam logic [ETYPE_W-1:0] ETYPE_IPV4 = 16'h0800;
   localparam logic [ETYPE_W-1:0] ETYPE_IPV6 = 16'h86DD;

   localparam logic [1:0] L3_OTHER = 2'd0;
   localparam logic [1:0] L3_IPV4  = 2'd1;
   localparam logic [1:0] L3_IPV6  = 2'd2;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0] state_q, state_d;
   logic       owner_q, owner_d;   // port holding the output while in LOCK
   logic       last_q,  last_d;    // port served most recently (loses next tie)
   logic       sop_q,   sop_d;     // next accepted beat starts a packet
   logic [1:0] l3_q,    l3_d;      // L3 type captured on the sop handshake

   logic       grant_vld;
   logic       grant_sel;
   logic       hs;
   logic       hs_last;
   logic [1:0] l3_dec;
   logic [ETYPE_W-1:0] etype;

   // Grant selection: locked owner wins, otherwise round-robin between valids
   always_comb begin
      grant_vld = 1'b0;
      grant_sel = 1'b0;
      if (state_q == ST_LOCK) begin
         grant_vld = 1'b1;
         grant_sel = owner_q;
      end else if (s0_axis_tvalid && s1_axis_tvalid) begin
         grant_vld = 1'b1;
         grant_sel = ~last_q;
      end else if (s1_axis_tvalid) begin
         grant_vld = 1'b1;
         grant_sel = 1'b1;
      end else if (s0_axis_tvalid) begin
         grant_vld = 1'b1;
         grant_sel = 1'b0;
      end
   end

   // Data path mux; handshakes are suppressed while reset is held
   always_comb begin
      m_axis_tdata     = grant_sel ? s1_axis_tdata : s0_axis_tdata;
      m_axis_tkeep     = grant_sel ? s1_axis_tkeep : s0_axis_tkeep;
      m_axis_tlast     = grant_sel ? s1_axis_tlast : s0_axis_tlast;
      m_axis_tuser_src = grant_sel;
      m_axis_tvalid    = grant_vld && !axis_rst &&
                         (grant_sel ? s1_axis_tvalid : s0_axis_tvalid);
      s0_axis_tready   = grant_vld && !axis_rst && !grant_sel && m_axis_tready;
      s1_axis_tready   = grant_vld && !axis_rst &&  grant_sel && m_axis_tready;
   end

   // EtherType decode of the beat currently on the output
   always_comb begin
      etype = m_axis_tdata[ETYPE_LSB +: ETYPE_W];
      if (etype == ETYPE_IPV4) begin
         l3_dec = L3_IPV4;
      end else if (etype == ETYPE_IPV6) begin
         l3_dec = L3_IPV6;
      end else begin
         l3_dec = L3_OTHER;
      end
      hs      = m_axis_tvalid && m_axis_tready;
      hs_last = hs && m_axis_tlast;
      m_axis_tuser_sop = sop_q;
      m_axis_tuser_l3  = sop_q ? l3_dec : l3_q;
   end

   // Next-state logic: ownership, round-robin pointer, sop and L3 tracking
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      sop_d   = sop_q;
      l3_d    = l3_q;

      if (hs) begin
         sop_d = m_axis_tlast;
         if (sop_q) begin
            l3_d = l3_dec;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (hs_last) begin
               last_d = grant_sel;
            end else if (grant_vld) begin
               state_d = ST_LOCK;
               owner_d = grant_sel;
            end
         end
         ST_LOCK: begin
            if (hs_last) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset leaves port 0 as winner of the first tie
   always_ff @(posedge axis_aclk) begin
      if (axis_rst) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         sop_q   <= 1'b1;
         l3_q    <= L3_OTHER;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         sop_q   <= sop_d;
         l3_q    <= l3_d;
      end
   end

`ifdef PKT_HDR_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   // Per-port packet counters; clear takes priority over a same-cycle count
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (hs_last && !grant_sel) begin
         cnt0_d = cnt0_q + CNT_W'(1);
      end
      if (hs_last && grant_sel) begin
         cnt1_d = cnt1_q + CNT_W'(1);
      end
      if (stats_clr) begin
         cnt0_d = '0;
         cnt1_d = '0;
      end
   end

   // Counter registers
   always_ff @(posedge axis_aclk) begin
      if (axis_rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
`else
   logic unused_stats_clr;

   assign unused_stats_clr = stats_clr;
   assign pkt_cnt0 = '0;
   assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_pkt_hdr_arb.sv
// Testbench for pkt_hdr_arb: directed scenarios followed by a randomized run,
// checked against a packet-level reference model of the arbiter.
module tb_pkt_hdr_arb;

   localparam int unsigned TDATA_W = 512;
   localparam int unsigned KEEP_W  = TDATA_W / 8;
   localparam int unsigned CNT_W   = 32;
`ifdef PKT_HDR_ARB_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               axis_rst;
   logic               s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
   logic [TDATA_W-1:0] s0_axis_tdata;
   logic [KEEP_W-1:0]  s0_axis_tkeep;
   logic               s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
   logic [TDATA_W-1:0] s1_axis_tdata;
   logic [KEEP_W-1:0]  s1_axis_tkeep;
   logic               m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [TDATA_W-1:0] m_axis_tdata;
   logic [KEEP_W-1:0]  m_axis_tkeep;
   logic               m_axis_tuser_src, m_axis_tuser_sop;
   logic [1:0]         m_axis_tuser_l3;
   logic               stats_clr;
   logic [CNT_W-1:0]   pkt_cnt0, pkt_cnt1;

   pkt_hdr_arb #(.TDATA_W(TDATA_W), .CNT_W(CNT_W)) dut (
      .axis_aclk        (clk),
      .axis_rst         (axis_rst),
      .s0_axis_tvalid   (s0_axis_tvalid),
      .s0_axis_tready   (s0_axis_tready),
      .s0_axis_tlast    (s0_axis_tlast),
      .s0_axis_tdata    (s0_axis_tdata),
      .s0_axis_tkeep    (s0_axis_tkeep),
      .s1_axis_tvalid   (s1_axis_tvalid),
      .s1_axis_tready   (s1_axis_tready),
      .s1_axis_tlast    (s1_axis_tlast),
      .s1_axis_tdata    (s1_axis_tdata),
      .s1_axis_tkeep    (s1_axis_tkeep),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tkeep     (m_axis_tkeep),
      .m_axis_tuser_src (m_axis_tuser_src),
      .m_axis_tuser_sop (m_axis_tuser_sop),
      .m_axis_tuser_l3  (m_axis_tuser_l3),
      .stats_clr        (stats_clr),
      .pkt_cnt0         (pkt_cnt0),
      .pkt_cnt1         (pkt_cnt1)
   );

   int total = 0;
   int bad   = 0;

   // Source-side packet generators
   bit                 vld [2];
   bit                 act [2];
   int                 idx [2];
   int                 len [2];
   logic [15:0]        hdr [2];
   logic [1:0]         cls [2];
   logic [TDATA_W-1:0] dat [2];
   logic [KEEP_W-1:0]  kp  [2];
   int                 len_cfg [2];   // 0 = random length
   int                 hdr_cfg [2];   // -1 = random EtherType

   // Reference model: packet owner (-1 none), last served port, packet counts
   int          m_owner;
   int          m_last;
   int unsigned m_cnt [2];

   int src_log [$];

   function automatic logic [1:0] l3_class(input logic [15:0] et);
      if (et == 16'h0800) return 2'd1;
      if (et == 16'h86DD) return 2'd2;
      return 2'd0;
   endfunction

   task automatic chk(input string tag, input logic [TDATA_W-1:0] obs, input logic [TDATA_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic prep(input int p, input bit go);
      if (!vld[p] && go) begin
         if (!act[p]) begin
            act[p] = 1'b1;
            idx[p] = 0;
            len[p] = (len_cfg[p] > 0) ? len_cfg[p] : int'($urandom_range(1, 5));
            if (hdr_cfg[p] >= 0) begin
               hdr[p] = 16'(hdr_cfg[p]);
            end else begin
               case ($urandom_range(0, 3))
                  0:       hdr[p] = 16'h0800;
                  1:       hdr[p] = 16'h86DD;
                  2:       hdr[p] = 16'h0806;
                  default: hdr[p] = 16'($urandom());
               endcase
            end
            cls[p] = l3_class(hdr[p]);
         end
         for (int w = 0; w < 16; w++) dat[p][w*32 +: 32] = $urandom();
         if (idx[p] == 0) dat[p][415:400] = hdr[p];
         kp[p]  = {$urandom(), $urandom()};
         vld[p] = 1'b1;
      end
   endtask

   task automatic apply_pins();
      s0_axis_tvalid = vld[0];
      s0_axis_tdata  = dat[0];
      s0_axis_tkeep  = kp[0];
      s0_axis_tlast  = (idx[0] == len[0] - 1);
      s1_axis_tvalid = vld[1];
      s1_axis_tdata  = dat[1];
      s1_axis_tkeep  = kp[1];
      s1_axis_tlast  = (idx[1] == len[1] - 1);
   endtask

   // Compare outputs with the model, then advance the model by one clock
   task automatic model_check(input bit mrdy, input bit clr);
      int sel;
      bit ev;
      sel = -1;
      if (m_owner >= 0)             sel = m_owner;
      else if (vld[0] && vld[1])    sel = 1 - m_last;
      else if (vld[0])              sel = 0;
      else if (vld[1])              sel = 1;
      ev = (sel == 0 && vld[0]) || (sel == 1 && vld[1]);

      chk("m_tvalid", TDATA_W'(m_axis_tvalid), TDATA_W'(ev));
      chk("s0_tready", TDATA_W'(s0_axis_tready), TDATA_W'(sel == 0 && mrdy));
      chk("s1_tready", TDATA_W'(s1_axis_tready), TDATA_W'(sel == 1 && mrdy));
      chk("pkt_cnt0", TDATA_W'(pkt_cnt0), TDATA_W'(STATS_EN ? m_cnt[0] : 0));
      chk("pkt_cnt1", TDATA_W'(pkt_cnt1), TDATA_W'(STATS_EN ? m_cnt[1] : 0));
      if (ev) begin
         chk("m_src",   TDATA_W'(m_axis_tuser_src), TDATA_W'(sel));
         chk("m_tdata", m_axis_tdata, dat[sel]);
         chk("m_tkeep", TDATA_W'(m_axis_tkeep), TDATA_W'(kp[sel]));
         chk("m_tlast", TDATA_W'(m_axis_tlast), TDATA_W'(idx[sel] == len[sel] - 1));
         chk("m_sop",   TDATA_W'(m_axis_tuser_sop), TDATA_W'(idx[sel] == 0));
         chk("m_l3",    TDATA_W'(m_axis_tuser_l3), TDATA_W'(cls[sel]));
      end

      if (ev && mrdy && idx[sel] == len[sel] - 1) begin
         m_owner = -1;
         m_last  = sel;
         m_cnt[sel]++;
      end else if (sel >= 0) begin
         m_owner = sel;
      end
      if (clr) begin
         m_cnt[0] = 0;
         m_cnt[1] = 0;
      end
   endtask

   task automatic advance();
      if (m_axis_tvalid && m_axis_tready) src_log.push_back(int'(m_axis_tuser_src));
      if (vld[0] && s0_axis_tready) begin
         idx[0]++;
         vld[0] = 1'b0;
         if (idx[0] == len[0]) act[0] = 1'b0;
      end
      if (vld[1] && s1_axis_tready) begin
         idx[1]++;
         vld[1] = 1'b0;
         if (idx[1] == len[1]) act[1] = 1'b0;
      end
   endtask

   task automatic step(input bit go0, input bit go1, input bit mrdy, input bit clr);
      @(posedge clk);
      #1;
      axis_rst      = 1'b0;
      m_axis_tready = mrdy;
      stats_clr     = clr;
      prep(0, go0);
      prep(1, go1);
      apply_pins();
      @(negedge clk);
      model_check(mrdy, clr);
      advance();
   endtask

   task automatic rst_step(input bit go0, input bit go1);
      @(posedge clk);
      #1;
      axis_rst      = 1'b1;
      m_axis_tready = 1'b1;
      stats_clr     = 1'b0;
      prep(0, go0);
      prep(1, go1);
      apply_pins();
      @(negedge clk);
      chk("rst_m_tvalid",  TDATA_W'(m_axis_tvalid),  '0);
      chk("rst_s0_tready", TDATA_W'(s0_axis_tready), '0);
      chk("rst_s1_tready", TDATA_W'(s1_axis_tready), '0);
      m_owner = -1;
      m_last  = 1;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      for (int p = 0; p < 2; p++) begin
         vld[p] = 1'b0;
         act[p] = 1'b0;
      end
   endtask

   initial begin
      axis_rst = 1'b1;
      m_axis_tready = 1'b0;
      stats_clr = 1'b0;
      for (int p = 0; p < 2; p++) begin
         vld[p] = 1'b0; act[p] = 1'b0; idx[p] = 0; len[p] = 1;
         hdr[p] = '0; cls[p] = '0; dat[p] = '0; kp[p] = '0;
         len_cfg[p] = 0; hdr_cfg[p] = -1;
      end
      m_owner = -1; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
      apply_pins();

      // Reset with both requesters asserting valid
      rst_step(1'b1, 1'b1);
      rst_step(1'b1, 1'b1);

      // Both valid, 3-beat packets, sink always ready: alternation, no bubbles
      len_cfg[0] = 3; len_cfg[1] = 3;
      src_log.delete();
      for (int c = 0; c < 12; c++) step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("alt3_beats", TDATA_W'(src_log.size()), TDATA_W'(12));
      for (int i = 0; i < src_log.size() && i < 12; i++)
         chk("alt3_src", TDATA_W'(src_log[i]), TDATA_W'((i / 3) % 2));

      // Sink stalls for 5 cycles while s0 owns; s1 arrives in cycle 2
      rst_step(1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("stall_src", TDATA_W'(m_axis_tuser_src), '0);
      for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b1, 1'b0);

      // L3 classification across consecutive packets
      rst_step(1'b0, 1'b0);
      len_cfg[0] = 4;
      hdr_cfg[0] = 32'h86DD;
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b1, 1'b0);
      hdr_cfg[0] = 32'h0800;
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b1, 1'b0);
      hdr_cfg[0] = 32'h0806;
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b1, 1'b0);
      hdr_cfg[0] = -1;

      // Single-beat packets on both ports: one packet per cycle, alternating
      rst_step(1'b0, 1'b0);
      len_cfg[0] = 1; len_cfg[1] = 1;
      src_log.delete();
      for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("alt1_beats", TDATA_W'(src_log.size()), TDATA_W'(8));
      for (int i = 0; i < src_log.size() && i < 8; i++)
         chk("alt1_src", TDATA_W'(src_log[i]), TDATA_W'(i % 2));

      // Reset during beat 2 of a 4-beat s1 packet; s0 wins the tie afterwards
      rst_step(1'b0, 1'b0);
      len_cfg[0] = 2; len_cfg[1] = 4;
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      rst_step(1'b1, 1'b1);
      src_log.delete();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("post_rst_sop", TDATA_W'(m_axis_tuser_sop), TDATA_W'(1));
      chk("post_rst_src", TDATA_W'(src_log.size() > 0 ? src_log[0] : -1), '0);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 1'b1, 1'b0);

      // Packet statistics: 5 on s0, 2 on s1, then clear on a tlast
      rst_step(1'b0, 1'b0);
      len_cfg[0] = 2; len_cfg[1] = 3;
      for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("stats_cnt0", TDATA_W'(pkt_cnt0), TDATA_W'(STATS_EN ? 5 : 0));
      chk("stats_cnt1", TDATA_W'(pkt_cnt1), TDATA_W'(STATS_EN ? 2 : 0));
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("clr_cnt0", TDATA_W'(pkt_cnt0), '0);
      chk("clr_cnt1", TDATA_W'(pkt_cnt1), '0);

      // Randomized traffic, backpressure, clears and occasional resets
      len_cfg[0] = 0; len_cfg[1] = 0;
      hdr_cfg[0] = -1; hdr_cfg[1] = -1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pkt_hdr_arb.md
PKT_HDR_ARB -- requirements
Module: pkt_hdr_arb

Interface
REQ-001 SHALL have parameter TDATA_W, default 512, AXI-stream data width in bits (only 512 supported; header bit offsets fixed).
REQ-002 SHALL have parameter CNT_W, default 32, width of each per-port packet counter.
REQ-003 SHALL have port axis_aclk, input, 1, the only clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port axis_rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have ports s0_axis_tvalid/tready/tlast (1 bit each), s0_axis_tdata (TDATA_W), s0_axis_tkeep (TDATA_W/8), requester 0 AXI-stream slave.
REQ-006 SHALL have ports s1_axis_* with identical names and widths, requester 1 AXI-stream slave.
REQ-007 SHALL have ports m_axis_tvalid/tready/tlast, m_axis_tdata, m_axis_tkeep, shared AXI-stream master toward the header classifier.
REQ-008 SHALL have port m_axis_tuser_src, output, 1, index of the granted requester.
REQ-009 SHALL have port m_axis_tuser_sop, output, 1, high on the first beat of each packet.
REQ-010 SHALL have port m_axis_tuser_l3, output, 2, L3 type: 0 other, 1 IPv4, 2 IPv6.
REQ-011 SHALL have ports stats_clr (input, 1), pkt_cnt0 and pkt_cnt1 (output, CNT_W each), statistics.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and LOCK (owner held until its tlast handshake).
REQ-013 In IDLE, grant SHALL be combinational: only one valid -> that port; both valid -> the port not served last (round-robin pointer).
REQ-014 Data path SHALL be a combinational mux: m_axis_* = granted s*_axis_*, m_axis_tready routed only to the granted s*_axis_tready; non-granted tready = 0.
REQ-015 IDLE -> LOCK SHALL occur when a grant exists and no handshake with tlast occurs that cycle (covers the m_axis_tready=0 stall, keeping tvalid/tdata stable per AXI-stream).
REQ-016 A single-beat packet (handshake with tlast in IDLE) SHALL leave the state in IDLE and update the pointer.
REQ-017 LOCK -> IDLE SHALL occur on the owner's handshake with tlast; the pointer SHALL then record that owner.
REQ-018 Back-to-back packets SHALL incur zero bubble cycles; the next grant is evaluated in the cycle after tlast.
REQ-019 m_axis_tuser_sop SHALL be 1 on the first beat after reset or after any tlast handshake, else 0.
REQ-020 On the sop beat, m_axis_tuser_l3 SHALL decode tdata[415:400]: 16'h0800 -> 1, 16'h86DD -> 2, else 0; on later beats it SHALL hold the value registered at the sop handshake.
REQ-021 The arbiter SHALL NOT preempt or truncate a packet; a requester dropping tvalid mid-packet stalls the output.

Reset
REQ-022 While axis_rst=1: state IDLE, pointer set so port 0 wins the first tie, sop flag 1, l3 register 0, counters 0.
REQ-023 While axis_rst=1, m_axis_tvalid and both s*_axis_tready SHALL be 0.
REQ-024 Reset mid-packet SHALL discard ownership; the next beat accepted is flagged sop; no recovery of the partial packet.

Configuration
REQ-025 With macro PKT_HDR_ARB_STATS_EN defined, pkt_cnt0/pkt_cnt1 SHALL increment by 1 on each tlast handshake from the respective port, wrap at 2^CNT_W, and clear on stats_clr (clear wins over a simultaneous increment).
REQ-026 Without PKT_HDR_ARB_STATS_EN, the ports SHALL remain, pkt_cnt0/pkt_cnt1 SHALL be constant 0, stats_clr SHALL be ignored, and no counter flops SHALL exist.

Verification
REQ-027 Both ports valid after reset, 3-beat packets, m_axis_tready=1 -> grants alternate 0,1,0,1; no bubbles; sop on beats 1,4,7.
REQ-028 s0 valid, m_axis_tready=0 for 5 cycles, s1 goes valid in cycle 2 -> m_axis_tdata/src stay on s0 throughout the stall; s1_axis_tready=0.
REQ-029 Packet with tdata[415:400]=16'h86DD, 4 beats -> m_axis_tuser_l3=2 on all 4 beats; the next packet with 16'h0800 -> 1; with 16'h0806 -> 0.
REQ-030 Single-beat packets back-to-back on both ports -> state stays IDLE, strict alternation, one packet per cycle.
REQ-031 axis_rst pulsed during beat 2 of a 4-beat s1 packet -> tvalid/tready 0 during reset; after release, s0 wins tie with sop=1.
REQ-032 With PKT_HDR_ARB_STATS_EN, 5 packets on s0, 2 on s1, then stats_clr coincident with a tlast -> 5/2 then 0/0.
